// File: rtl/iq_capture_pkg.sv
// Shared encodings for the multi-channel IQ capture buffer.
package iq_capture_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_CONT    = 2'd1;
  localparam logic [1:0] MODE_TRIG    = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StPre,
    StArmed,
    StPost,
    StDone
  } state_e;

  // Channel-select width for a given channel count, never below one bit.
  function automatic int unsigned ch_sel_width(input int unsigned nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/iq_capture_ram.sv
// Simple dual-port frame RAM: one write port, one registered read-first read port.
module iq_capture_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register clears on reset so the read port shows zero until the first read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/iq_capture_nch.sv
// Multi-channel IQ capture buffer: NCH I/Q lanes per frame in one wide dual-port RAM,
// with one-shot, continuous and pre-triggered capture plus the rd_sync/rd_i/rd_q readout.
module iq_capture_nch
  import iq_capture_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned A_MSB = 12,
  parameter int unsigned CW    = ch_sel_width(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic              trig,
  input  logic [A_MSB:0]    pretrig,
  input  logic              wr,
  input  logic [NCH*DW-1:0] wr_i,
  input  logic [NCH*DW-1:0] wr_q,
  input  logic              rd_sync,
  input  logic [A_MSB:0]    rd_offset,
  input  logic [CW-1:0]     rd_ch,
  input  logic              rd_i,
  input  logic              rd_q,
  output logic [DW-1:0]     rd_iq,
  output logic              busy,
  output logic              done,
  output logic              triggered,
  output logic [A_MSB:0]    trig_addr
);

  localparam int unsigned AW    = A_MSB + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CNTW  = AW + 1;
  localparam int unsigned WW    = 2 * NCH * DW;

  state_e          state_q, state_d;
  logic [AW-1:0]   pretrig_q, pretrig_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;
  logic            done_q, done_d;
  logic            triggered_q, triggered_d;

  logic            we;
  logic [CNTW-1:0] cnt_inc;
  logic [CNTW-1:0] post_len;

  assign we       = wr && (state_q inside {StFill, StRun, StPre, StArmed, StPost});
  assign cnt_inc  = cnt_q + CNTW'(1);
  assign post_len = CNTW'(DEPTH) - {1'b0, pretrig_q};

  // The capture mode lives in the state itself, so only pretrig needs latching on arm.
  // pretrig is AW bits wide, which already bounds it to DEPTH-1.
  always_comb begin
    state_d     = state_q;
    pretrig_d   = pretrig_q;
    wr_addr_d   = wr_addr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    done_d      = done_q;
    triggered_d = triggered_q;

    if (we) begin
      wr_addr_d = wr_addr_q + AW'(1);
    end

    if (arm) begin
      pretrig_d   = pretrig;
      wr_addr_d   = '0;
      cnt_d       = '0;
      done_d      = 1'b0;
      triggered_d = 1'b0;
      case (mode)
        MODE_ONESHOT: state_d = StFill;
        MODE_CONT:    state_d = StRun;
        MODE_TRIG:    state_d = (pretrig == '0) ? StArmed : StPre;
        default:      state_d = StFill;
      endcase
    end else begin
      unique case (state_q)
        StFill: begin
          if (we) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNTW'(DEPTH)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StPre: begin
          if (we) begin
            cnt_d = cnt_inc;
            if (cnt_inc == {1'b0, pretrig_q}) begin
              state_d = StArmed;
            end
          end
        end
        StArmed: begin
          // The trigger frame itself is the first post-trigger frame.
          if (we && trig) begin
            trig_addr_d = wr_addr_q;
            triggered_d = 1'b1;
            cnt_d       = CNTW'(1);
            if (post_len == CNTW'(1)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StPost;
            end
          end
        end
        StPost: begin
          if (we) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_len) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pretrig_q   <= '0;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      done_q      <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pretrig_q   <= pretrig_d;
      wr_addr_q   <= wr_addr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      done_q      <= done_d;
      triggered_q <= triggered_d;
    end
  end

  assign busy      = !(state_q inside {StIdle, StDone});
  assign done      = done_q;
  assign triggered = triggered_q;
  assign trig_addr = trig_addr_q;

  // Read side: rd_next feeds the RAM directly so data for a resync shows up one cycle later.
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] rd_next;
  logic          rd_en;
  logic [WW-1:0] rd_word;

  assign rd_next = rd_sync ? (wr_addr_q + rd_offset) : (rd_addr_q + AW'(rd_q));
  assign rd_en   = rd_sync || rd_i || rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= rd_next;
    end
  end

  iq_capture_ram #(
    .WIDTH (WW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_addr_q),
    .wdata ({wr_q, wr_i}),
    .re    (rd_en),
    .raddr (rd_next),
    .rdata (rd_word)
  );

  // Word layout: all I lanes in the low half, all Q lanes in the high half.
  always_comb begin
    rd_iq = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (rd_ch == CW'(n)) begin
        rd_iq = rd_i ? rd_word[n*DW +: DW] : rd_word[NCH*DW + n*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_iq_capture_nch.sv
// Scoreboard bench for iq_capture_nch: stimulus queues expected values, a negedge monitor checks.
module tb_iq_capture_nch;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DW    = 16;
  localparam int unsigned A_MSB = 3;
  localparam int unsigned CW    = 2;
  localparam int unsigned AW    = A_MSB + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mode = '0;
  logic              arm = 1'b0;
  logic              trig = 1'b0;
  logic [AW-1:0]     pretrig = '0;
  logic              wr = 1'b0;
  logic [NCH*DW-1:0] wr_i = '0;
  logic [NCH*DW-1:0] wr_q = '0;
  logic              rd_sync = 1'b0;
  logic [AW-1:0]     rd_offset = '0;
  logic [CW-1:0]     rd_ch = '0;
  logic              rd_i = 1'b0;
  logic              rd_q = 1'b0;
  logic [DW-1:0]     rd_iq;
  logic              busy;
  logic              done;
  logic              triggered;
  logic [AW-1:0]     trig_addr;

  logic              stat_strobe = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          use_iq;
    logic          busy;
    logic          done;
    logic          triggered;
    logic [AW-1:0] taddr;
    logic [DW-1:0] iq;
  } stat_t;

  logic [DW-1:0] rd_exp_q[$];
  string         rd_name_q[$];
  stat_t         stat_exp_q[$];
  string         stat_name_q[$];

  iq_capture_nch #(
    .NCH   (NCH),
    .DW    (DW),
    .A_MSB (A_MSB),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .arm       (arm),
    .trig      (trig),
    .pretrig   (pretrig),
    .wr        (wr),
    .wr_i      (wr_i),
    .wr_q      (wr_q),
    .rd_sync   (rd_sync),
    .rd_offset (rd_offset),
    .rd_ch     (rd_ch),
    .rd_i      (rd_i),
    .rd_q      (rd_q),
    .rd_iq     (rd_iq),
    .busy      (busy),
    .done      (done),
    .triggered (triggered),
    .trig_addr (trig_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Lane c of frame value v: I carries the channel number in bit 12 upward, Q = ~I.
  function automatic logic [DW-1:0] ival(input int unsigned v, input int unsigned c);
    return DW'(v + c * 32'h1000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [AW-1:0] p, input logic t,
                        input logic w);
    arm = 1'b1; mode = m; pretrig = p; trig = t; wr = w;
    tick();
    arm = 1'b0; trig = 1'b0; wr = 1'b0;
  endtask

  task automatic do_wr(input int unsigned v, input logic t);
    wr = 1'b1; trig = t;
    for (int unsigned c = 0; c < NCH; c++) begin
      wr_i[c*DW +: DW] = ival(v, c);
      wr_q[c*DW +: DW] = ~ival(v, c);
    end
    tick();
    wr = 1'b0; trig = 1'b0;
  endtask

  task automatic exp_rd(input logic [DW-1:0] v, input string nm);
    rd_exp_q.push_back(v);
    rd_name_q.push_back(nm);
  endtask

  task automatic read_frames(input logic [AW-1:0] off, input logic [CW-1:0] ch,
                             input int unsigned first, input int unsigned count,
                             input string nm);
    rd_sync = 1'b1; rd_offset = off;
    tick();
    rd_sync = 1'b0;
    for (int unsigned k = 0; k < count; k++) begin
      rd_ch = ch; rd_i = 1'b1;
      exp_rd(ival(first + k, ch), nm);
      tick();
      rd_i = 1'b0; rd_q = 1'b1;
      exp_rd(~ival(first + k, ch), nm);
      tick();
      rd_q = 1'b0;
    end
  endtask

  task automatic chk_stat(input logic b, input logic d, input logic t, input logic [AW-1:0] ta,
                          input logic use_iq, input string nm);
    stat_t s;
    s.use_iq = use_iq; s.busy = b; s.done = d; s.triggered = t; s.taddr = ta; s.iq = '0;
    stat_exp_q.push_back(s);
    stat_name_q.push_back(nm);
    stat_strobe = 1'b1;
    tick();
    stat_strobe = 1'b0;
  endtask

  // Monitor: reads are checked on every rd_i/rd_q strobe, status on every status strobe.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    stat_t         s;
    string         nm;
    if (rd_i || rd_q) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_iq=%h with no expected value queued", rd_iq);
      end else begin
        e  = rd_exp_q.pop_front();
        nm = rd_name_q.pop_front();
        if (rd_iq !== e) begin
          errors++;
          $display("FAIL %s: rd_iq got %h expected %h", nm, rd_iq, e);
        end
      end
    end
    if (stat_strobe) begin
      checks++;
      if (stat_exp_q.size() == 0) begin
        errors++;
        $display("FAIL stat_unexpected: no expected status queued");
      end else begin
        s  = stat_exp_q.pop_front();
        nm = stat_name_q.pop_front();
        if ({busy, done, triggered, trig_addr} !== {s.busy, s.done, s.triggered, s.taddr} ||
            (s.use_iq && rd_iq !== s.iq)) begin
          errors++;
          $display("FAIL %s: busy/done/trig/taddr/iq got %b/%b/%b/%0d/%h expected %b/%b/%b/%0d/%h",
                   nm, busy, done, triggered, trig_addr, rd_iq,
                   s.busy, s.done, s.triggered, s.taddr, s.iq);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk_stat(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "reset_state");

    // One-shot: 20 strobes, only the first 16 land.
    do_arm(2'd0, 4'd0, 1'b0, 1'b0);
    for (int unsigned n = 0; n < 5; n++) do_wr(n, 1'b0);
    chk_stat(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "oneshot_busy");
    for (int unsigned n = 5; n < 20; n++) do_wr(n, 1'b0);
    chk_stat(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "oneshot_done");
    read_frames(4'd0, 2'd0, 0, 16, "oneshot_rd_ch0");
    read_frames(4'd0, 2'd1, 0, 16, "oneshot_rd_ch1");

    // Continuous: 37 writes leave wr_addr at 5, oldest frame 21.
    do_arm(2'd1, 4'd0, 1'b0, 1'b0);
    for (int unsigned n = 0; n < 37; n++) do_wr(n, 1'b0);
    chk_stat(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "cont_status");
    read_frames(4'd0, 2'd1, 21, 16, "cont_rd_ch1");

    // Triggered, pretrig 4, trigger on frame 10, done after frame 21.
    do_arm(2'd2, 4'd4, 1'b0, 1'b0);
    for (int unsigned n = 0; n < 10; n++) do_wr(32'h300 + n, 1'b0);
    chk_stat(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "trig4_armed");
    do_wr(32'h30a, 1'b1);
    for (int unsigned n = 11; n < 21; n++) do_wr(32'h300 + n, 1'b0);
    chk_stat(1'b1, 1'b0, 1'b1, 4'd10, 1'b0, "trig4_not_done_yet");
    do_wr(32'h315, 1'b0);
    do_wr(32'h316, 1'b0);
    do_wr(32'h317, 1'b0);
    chk_stat(1'b0, 1'b1, 1'b1, 4'd10, 1'b0, "trig4_done");
    read_frames(4'd0, 2'd0, 32'h306, 16, "trig4_rd_window");
    read_frames(4'd4, 2'd1, 32'h30a, 1, "trig4_rd_trigframe");

    // Triggered, pretrig 0: re-arm from ARMED with wr+trig, trigger must not be taken.
    do_arm(2'd2, 4'd0, 1'b0, 1'b0);
    do_arm(2'd2, 4'd0, 1'b1, 1'b1);
    chk_stat(1'b1, 1'b0, 1'b0, 4'd10, 1'b0, "trig0_arm_wins");
    do_wr(32'h400, 1'b1);
    for (int unsigned n = 1; n < 15; n++) do_wr(32'h400 + n, 1'b0);
    chk_stat(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, "trig0_post_15");
    do_wr(32'h40f, 1'b0);
    chk_stat(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "trig0_done");
    read_frames(4'd0, 2'd1, 32'h400, 4, "trig0_rd");

    // Trigger ignored during PRE, then reset in the middle of POST.
    do_arm(2'd2, 4'd8, 1'b0, 1'b0);
    for (int unsigned n = 0; n < 8; n++) do_wr(32'h500 + n, (n == 2) || (n == 5));
    chk_stat(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "pre_trig_ignored");
    do_wr(32'h508, 1'b1);
    do_wr(32'h509, 1'b0);
    do_wr(32'h50a, 1'b0);
    chk_stat(1'b1, 1'b0, 1'b1, 4'd8, 1'b0, "post_running");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_stat(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "rst_mid_post");
    do_wr(32'h0ee, 1'b1);
    chk_stat(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "idle_after_rst");
    read_frames(4'd0, 2'd0, 32'h500, 1, "idle_wr_dropped");

    // Read protocol: consecutive frames, hold on rd_i, out-of-range channel, sync over advance.
    read_frames(4'd3, 2'd1, 32'h503, 2, "proto_pairs");
    rd_ch = 2'd1; rd_i = 1'b1;
    exp_rd(ival(32'h505, 1), "proto_addr_plus2");
    tick();
    rd_ch = 2'd3;
    exp_rd(16'h0000, "proto_ch3_zero");
    tick();
    rd_i = 1'b0;
    rd_ch = 2'd0; rd_sync = 1'b1; rd_q = 1'b1; rd_offset = 4'd1;
    exp_rd(~ival(32'h505, 0), "proto_sync_cycle_q");
    tick();
    rd_sync = 1'b0; rd_q = 1'b0; rd_i = 1'b1;
    exp_rd(ival(32'h501, 0), "proto_sync_priority");
    tick();
    rd_i = 1'b0;
    tick();

    checks++;
    if (rd_exp_q.size() != 0 || stat_exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending rd=%0d stat=%0d expected 0/0",
               rd_exp_q.size(), stat_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_capture_nch.md
Name: iq_capture_nch

Overview:
- Multi-channel IQ capture buffer; parametrised successor of the single-channel 8K x 32b IQ sampler.
- Stores NCH channels of I/Q per sample frame in one wide dual-port BRAM.
- Capture modes: one-shot, continuous, and triggered with programmable pre-trigger depth.
- Single clock domain, placed after the per-channel decimators; read side serves the CPU readout path using the existing rd_sync/rd_offset/rd_i/rd_q protocol, extended with channel select.

Parameters:
- NCH, 4, number of IQ channels captured per frame (1..8)
- DW, 16, bits per I or Q sample
- A_MSB, 12, address MSB; DEPTH = 2^(A_MSB+1) frames
- CW, 2, channel-select width, >= clog2(NCH), min 1

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  0=one-shot, 1=continuous, 2=triggered, 3=reserved (treated as one-shot); sampled on arm
- arm  in  1  start/restart capture
- trig  in  1  trigger qualifier, used in triggered mode only
- pretrig  in  A_MSB+1  pre-trigger frame count; sampled on arm
- wr  in  1  frame strobe, all channels valid
- wr_i  in  NCH*DW  packed I, channel n at [n*DW +: DW]
- wr_q  in  NCH*DW  packed Q, same packing
- rd_sync  in  1  rd_addr <= wr_addr + rd_offset
- rd_offset  in  A_MSB+1  read offset, modulo DEPTH
- rd_ch  in  CW  channel select for rd_iq
- rd_i  in  1  select I half; no address advance
- rd_q  in  1  select Q half; advance rd_addr after this read
- rd_iq  out  DW  selected sample
- busy  out  1  capture in progress (state not IDLE/DONE)
- done  out  1  one-shot/triggered capture complete
- triggered  out  1  trigger accepted in current capture
- trig_addr  out  A_MSB+1  wr_addr at accepted trigger frame

Behaviour:
- Reset: state=IDLE; wr_addr, rd_addr, cnt, trig_addr = 0; busy, done, triggered = 0; rd_iq = 0 until first read.
- Write enable we = wr && state in {FILL, RUN, PRE, ARMED, POST}. Each we writes {I,Q} for all channels at wr_addr, then wr_addr increments modulo DEPTH.
- Write address wraps freely in RUN, PRE, and ARMED.
- FSM states: IDLE, FILL, RUN, PRE, ARMED, POST, DONE.
- arm from any state: clears done/triggered, zeroes cnt, wr_addr = 0, latches mode and pretrig (clamped to DEPTH-1). Next state:
  - one-shot -> FILL
  - continuous -> RUN
  - triggered -> PRE, or ARMED if pretrig == 0
- FILL: cnt counts we; on the DEPTH-th write -> DONE.
- RUN: writes indefinitely; busy=1; done never set; exits only on arm or rst.
- PRE: cnt counts we; when cnt reaches pretrig -> ARMED. trig ignored in PRE.
- ARMED: on we && trig:
  - trig_addr <= wr_addr, triggered <= 1, cnt <= 1, -> POST
  - the trigger frame is the first post-trigger frame
- POST: counts we; when cnt reaches DEPTH - pretrig -> DONE.
- DONE: no writes; done=1 held until next arm or rst.
- arm and trig in the same cycle: arm wins; trig is not accepted.
- After DONE in triggered mode, wr_addr = trig_addr + DEPTH - pretrig (mod DEPTH). Therefore rd_sync with rd_offset=0 addresses the oldest frame, trig_addr - pretrig.
- Read side:
  - rd_next = rd_addr + rd_q; BRAM port B address = rd_next; registered output, 1-cycle latency.
  - rd_iq is combinational from the registered word: rd_i ? I[rd_ch] : Q[rd_ch].
  - Caller strobes rd_i then rd_q per frame and samples rd_iq in each strobe cycle.
  - rd_sync has priority over rd_q advance. The first valid data appears the cycle after rd_sync.
  - rd_ch >= NCH returns 0.
  - rst zeroes rd_addr.
- Reading during capture is permitted and returns whatever the RAM holds; no read/write collision protection. Same-address same-cycle read returns old data (read-first).

Decomposition:
- Shared package iq_capture_pkg holds:
  - mode encodings MODE_ONESHOT / MODE_CONT / MODE_TRIG
  - FSM state encoding
  - helper function for CW from NCH
- Sub-module iq_capture_ram: simple dual-port RAM, width NCH*2*DW, DEPTH entries, registered read, read-first. It maps to the BRAM core when NCH*2*DW = 32.
- FSM, counters, and read mux stay in the top module.

Test Plan:
Bench configuration: A_MSB=3 (DEPTH 16), NCH=2, DW=16, counting data I = frame number n, Q = ~n.
- One-shot: arm, 20 wr strobes -> done after the 16th write, wr_addr=0, frames 0..15 stored. rd_sync offset 0, then rd_i/rd_q pairs read I = 0..15 for rd_ch=0 and rd_ch=1.
- Continuous: arm, 37 writes -> busy=1, done=0, wr_addr=5. rd_sync offset 0 reads oldest frame 21 through 36.
- Triggered, pretrig=4: 10 writes, then trig on frame 10 -> trig_addr=10, done after frame 21. rd_sync offset 0 reads frames 6..21; trig frame at offset 4.
- Triggered, pretrig=0, trig asserted at the same cycle as arm -> not accepted. trig on next wr -> trig_addr=0; 16 post frames; done.
- trig during PRE (pretrig=8, trig on frames 2 and 5) ignored -> triggered=0 until ARMED. rst mid-POST -> all outputs 0, state IDLE, subsequent wr not written.
- Read protocol: rd_i, rd_q, rd_i, rd_q with rd_ch=1 -> I1/Q1 of consecutive frames; rd_addr advances by 2. rd_ch=3 -> rd_iq=0.
